// File: rtl/bmp_header_parser_if.sv
// rtl/bmp_header_parser_if.sv - start/done handshake, header memory read port and parsed fields
interface bmp_header_parser_if;
  logic        start;
  logic        done;
  logic        valid;
  logic [23:0] addr;
  logic        rden;
  logic [15:0] rddata;
  logic [31:0] file_size;
  logic [31:0] data_offset;
  logic [31:0] img_width;
  logic [31:0] img_height;
  logic [15:0] bpp;
  logic [3:0]  err;

  // Controller and header memory side
  modport master (
    output start, rddata,
    input  done, valid, addr, rden, file_size, data_offset, img_width, img_height, bpp, err
  );

  // Parser side
  modport slave (
    input  start, rddata,
    output done, valid, addr, rden, file_size, data_offset, img_width, img_height, bpp, err
  );
endinterface

// File: rtl/bmp_header_parser.sv
// rtl/bmp_header_parser.sv - reads a byte-per-word BMP header and extracts size/offset/geometry/bpp
module bmp_header_parser #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [15:0] EXP_BPP   = 16'd24
) (
  input logic                clk,
  input logic                rst_n,
  bmp_header_parser_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CHECK, S_DONE} state_t;

  localparam logic [4:0] NUM_BYTES = 5'd30;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;          // next header byte to request
  logic        rden_q, rden_d;
  logic [23:0] addr_q, addr_d;
  logic [4:0]  iss_idx_q, iss_idx_d;  // header byte index carried by addr_q
  logic        cap_vld_q, cap_vld_d;  // rddata holds a requested byte this cycle
  logic [4:0]  cap_idx_q, cap_idx_d;
  logic [15:0] sig_q, sig_d;
  logic [31:0] fsize_q, fsize_d;
  logic [31:0] doff_q, doff_d;
  logic [31:0] width_q, width_d;
  logic [31:0] height_q, height_d;
  logic [15:0] bpp_q, bpp_d;
  logic [3:0]  err_q, err_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;

  logic [7:0]  byte_in;
  logic [1:0]  lane;
  logic [3:0]  err_chk;

  assign byte_in = bus.rddata[7:0];
  // Every 32-bit field starts at an index that is 2 mod 4, so the lane is idx-2 mod 4
  assign lane    = cap_idx_q[1:0] - 2'd2;

  // Sanity mask over the captured header
  always_comb begin
    err_chk    = 4'b0000;
    err_chk[0] = (sig_q != 16'h4D42);
    err_chk[1] = (doff_q != 32'd54);
    err_chk[2] = (bpp_q != EXP_BPP);
    err_chk[3] = (width_q == 32'd0) || (height_q == 32'd0);
  end

  // Byte capture into little-endian fields, then sequencing of the parse
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rden_d    = 1'b0;
    addr_d    = addr_q;
    iss_idx_d = iss_idx_q;
    cap_vld_d = rden_q;
    cap_idx_d = iss_idx_q;
    sig_d     = sig_q;
    fsize_d   = fsize_q;
    doff_d    = doff_q;
    width_d   = width_q;
    height_d  = height_q;
    bpp_d     = bpp_q;
    err_d     = err_q;
    done_d    = done_q;
    valid_d   = valid_q;

    if (cap_vld_q) begin
      if (cap_idx_q <= 5'd1)
        sig_d[{cap_idx_q[0], 3'b000} +: 8] = byte_in;
      else if (cap_idx_q <= 5'd5)
        fsize_d[{lane, 3'b000} +: 8] = byte_in;
      else if (cap_idx_q >= 5'd10 && cap_idx_q <= 5'd13)
        doff_d[{lane, 3'b000} +: 8] = byte_in;
      else if (cap_idx_q >= 5'd18 && cap_idx_q <= 5'd21)
        width_d[{lane, 3'b000} +: 8] = byte_in;
      else if (cap_idx_q >= 5'd22 && cap_idx_q <= 5'd25)
        height_d[{lane, 3'b000} +: 8] = byte_in;
      else if (cap_idx_q >= 5'd28)
        bpp_d[{cap_idx_q[0], 3'b000} +: 8] = byte_in;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_READ;
          idx_d    = 5'd0;
          sig_d    = 16'd0;
          fsize_d  = 32'd0;
          doff_d   = 32'd0;
          width_d  = 32'd0;
          height_d = 32'd0;
          bpp_d    = 16'd0;
          err_d    = 4'd0;
          done_d   = 1'b0;
          valid_d  = 1'b0;
        end
      end
      S_READ: begin
        if (idx_q == NUM_BYTES) begin
          state_d = S_DRAIN;
        end else begin
          rden_d    = 1'b1;
          addr_d    = BASE_ADDR + {19'd0, idx_q};
          iss_idx_d = idx_q;
          idx_d     = idx_q + 5'd1;
        end
      end
      S_DRAIN: state_d = S_CHECK;
      S_CHECK: begin
        err_d   = err_chk;
        valid_d = (err_chk == 4'd0);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any read still in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      rden_q    <= 1'b0;
      addr_q    <= 24'd0;
      iss_idx_q <= 5'd0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= 5'd0;
      sig_q     <= 16'd0;
      fsize_q   <= 32'd0;
      doff_q    <= 32'd0;
      width_q   <= 32'd0;
      height_q  <= 32'd0;
      bpp_q     <= 16'd0;
      err_q     <= 4'd0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rden_q    <= rden_d;
      addr_q    <= addr_d;
      iss_idx_q <= iss_idx_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      sig_q     <= sig_d;
      fsize_q   <= fsize_d;
      doff_q    <= doff_d;
      width_q   <= width_d;
      height_q  <= height_d;
      bpp_q     <= bpp_d;
      err_q     <= err_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.rden        = rden_q;
  assign bus.addr        = addr_q;
  assign bus.done        = done_q;
  assign bus.valid       = valid_q;
  assign bus.err         = err_q;
  assign bus.file_size   = fsize_q;
  assign bus.data_offset = doff_q;
  assign bus.img_width   = width_q;
  assign bus.img_height  = height_q;
  assign bus.bpp         = bpp_q;

endmodule

// File: doc/bmp_header_parser.md
# bmp_header_parser

Reads a 54-byte BMP file header back out of the frame/file memory, one byte per word, and extracts the fields the rest of the image path needs: file size, pixel-data offset, width, height and bits-per-pixel. It is the read-side counterpart of the header writer: both use the same byte-per-word memory layout with little-endian multi-byte fields. It runs on a start/done handshake and reports header sanity errors as a bit mask.

## Interface
- BASE_ADDR, 24'h000000, word address of header byte 0
- EXP_BPP, 24, bits-per-pixel value accepted as valid
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a parse; sampled only in IDLE and DONE
- done  out  1  high while in DONE, held until the next accepted start
- valid  out  1  done && (err == 0)
- addr  out  24  memory read address, registered
- rden  out  1  memory read enable, registered
- rddata  in  16  memory read data, valid exactly 1 cycle after the rden cycle; bits [15:8] ignored
- file_size  out  32  header bytes 2..5
- data_offset  out  32  header bytes 10..13
- img_width  out  32  header bytes 18..21
- img_height  out  32  header bytes 22..25
- bpp  out  16  header bytes 28..29
- err  out  4  bit0 bad signature, bit1 offset != 54, bit2 bpp != EXP_BPP, bit3 width or height zero

## Operation
- States: IDLE, READ, DRAIN, CHECK, DONE.
- IDLE: start=1 -> clear all field registers and err, set index=0, go to READ.
- READ: rden=1, addr=BASE_ADDR+index, where index runs 0..29, one per cycle. Addition is mod 2^24, so addresses wrap. After index 29 is issued, go to DRAIN.
- Byte capture: each cycle after a rden cycle, rddata[7:0] is written into the field byte selected by the delayed index. Multi-byte fields are little-endian: the lowest address is the LSB. Bytes 0..1 go to the signature register. Bytes 6..9, 14..17 and 26..27 are read and discarded.
- DRAIN: rden=0; byte 29 is captured; go to CHECK.
- CHECK: compute err from the captured bytes:
  - bit0 set unless byte0==66 and byte1==77 ('B','M')
  - bit1 set unless data_offset==54
  - bit2 set unless bpp==EXP_BPP
  - bit3 set if img_width==0 or img_height==0
  - Go to DONE.
- DONE: done=1. Fields and err hold their values. start=1 restarts exactly as from IDLE, and done drops the next cycle.
- start is ignored in READ, DRAIN and CHECK.
- Fields are reported as read even when err != 0.
- Reset, at any time including mid-parse: the next cycle has state=IDLE, rden=0, addr=0, done=0, valid=0, err=0 and all fields 0. Any data returning from an in-flight read is dropped.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Let start be sampled high at edge 0. Then:
  - edges 1..30: rden=1, addr=BASE+0..BASE+29
  - edge 31: DRAIN
  - edge 32: CHECK
  - edge 33 onward: done=1, with valid and err final in the same cycle
- Latency from accepted start to done is 33 cycles. There are exactly 30 read cycles per parse, with no gaps.
- A restart from DONE has the same 33-cycle latency, and done=0 from edge 1 after the start.

## Test plan
- Memory holds a valid header: 'BM', file_size 30054, offset 54, 100x100, bpp 24. Pulse start -> exactly 30 reads at addr 0..29; done at cycle 33; file_size=30054, data_offset=54, img_width=100, img_height=100, bpp=24, err=0, valid=1.
- Same header with byte1=78 ('BN') -> err=4'b0001, valid=0, other fields as above.
- bpp=32 and offset=138 -> err=4'b0110; data_offset=138, bpp=32 reported.
- height=0 -> err=4'b1000. Then re-pulse start in DONE after fixing height to 50 -> done low at cycle 1, high again at cycle 33 with err=0 and img_height=50.
- start pulsed again at cycle 10 of a parse -> ignored: reads stay contiguous and done still arrives at cycle 33.
- rst_n low at cycle 15 mid-READ -> next cycle rden=0 and all outputs 0; a fresh start gives a correct parse.
- BASE_ADDR=24'hFFFFF0 with rddata[15:8]=8'hAB on every word -> addresses 0xFFFFF0..0xFFFFFF then 0x000000..0x00000D; fields are unaffected by the upper byte.
